// File: rtl/riscv_pkg.sv
// Shared RISC-V encoding constants: request class codes, base opcodes, encoder FSM states
// and small helpers used by the instruction encoder and the main decoder.
package riscv_pkg;

  // Request class codes carried on req_class; 9..15 are illegal.
  localparam logic [3:0] ClsLoad   = 4'd0;
  localparam logic [3:0] ClsStore  = 4'd1;
  localparam logic [3:0] ClsR      = 4'd2;
  localparam logic [3:0] ClsBranch = 4'd3;
  localparam logic [3:0] ClsIAlu   = 4'd4;
  localparam logic [3:0] ClsJal    = 4'd5;
  localparam logic [3:0] ClsAuipc  = 4'd6;
  localparam logic [3:0] ClsLui    = 4'd7;
  localparam logic [3:0] ClsJalr   = 4'd8;

  // Base opcodes.
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpIAlu   = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } enc_state_e;

  // Opcode for a request class; zero for illegal classes.
  function automatic logic [6:0] class_opcode(logic [3:0] cls);
    logic [6:0] op;
    case (cls)
      ClsLoad:   op = OpLoad;
      ClsStore:  op = OpStore;
      ClsR:      op = OpR;
      ClsBranch: op = OpBranch;
      ClsIAlu:   op = OpIAlu;
      ClsJal:    op = OpJal;
      ClsAuipc:  op = OpAuipc;
      ClsLui:    op = OpLui;
      ClsJalr:   op = OpJalr;
      default:   op = 7'b0;
    endcase
    return op;
  endfunction

  // True when v is a sign-extension of its low msb+1 bits.
  function automatic logic fits_signed(logic [31:0] v, int msb);
    logic [31:0] t;
    t = $unsigned($signed(v) >>> msb);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Immediate packer: places the immediate bits of a request at their instruction-word
// positions (all other bits zero) and checks the immediate is representable.
//   i_class    : request class code
//   i_imm      : signed byte offset or upper value
//   o_imm_bits : immediate scattered into instruction-word bit positions
//   o_range_ok : immediate representable; also 0 for illegal classes
module imm_pack
  import riscv_pkg::*;
(
  input  logic [3:0]  i_class,
  input  logic [31:0] i_imm,
  output logic [31:0] o_imm_bits,
  output logic        o_range_ok
);

  always_comb begin
    o_imm_bits = '0;
    o_range_ok = 1'b0;
    case (i_class)
      ClsLoad, ClsIAlu, ClsJalr: begin
        o_imm_bits[31:20] = i_imm[11:0];
        o_range_ok        = fits_signed(i_imm, 11);
      end
      ClsStore: begin
        o_imm_bits[31:25] = i_imm[11:5];
        o_imm_bits[11:7]  = i_imm[4:0];
        o_range_ok        = fits_signed(i_imm, 11);
      end
      ClsBranch: begin
        o_imm_bits[31]    = i_imm[12];
        o_imm_bits[30:25] = i_imm[10:5];
        o_imm_bits[11:8]  = i_imm[4:1];
        o_imm_bits[7]     = i_imm[11];
        o_range_ok        = fits_signed(i_imm, 12) && !i_imm[0];
      end
      ClsJal: begin
        o_imm_bits[31]    = i_imm[20];
        o_imm_bits[30:21] = i_imm[10:1];
        o_imm_bits[20]    = i_imm[11];
        o_imm_bits[19:12] = i_imm[19:12];
        o_range_ok        = fits_signed(i_imm, 20) && !i_imm[0];
      end
      ClsAuipc, ClsLui: begin
        o_imm_bits[31:12] = i_imm[31:12];
        o_range_ok        = (i_imm[11:0] == 12'h000);
      end
      ClsR: begin
        o_range_ok = 1'b1;
      end
      default: begin
        o_range_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded instruction requests, encodes them to RV32 words
// and writes them to consecutive instruction-memory addresses starting at base_addr.
//   clk, reset         : clock, asynchronous active-high reset
//   start, base_addr   : begin a program load at base_addr (word aligned)
//   req_*              : request handshake and fields (class, funct3, funct7b5, regs, imm)
//   imem_we/addr/wdata : instruction-memory write port, one cycle after accept
//   count, done, error : words written since start, program finished, sticky error
module instr_encoder
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_class,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic        req_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [15:0] count,
  output logic        done,
  output logic        error
);

  enc_state_e  r_state, w_state_d;
  logic [31:0] r_next_addr, r_addr, r_wdata;
  logic [15:0] r_count;
  logic        r_we, r_error;

  logic [31:0] w_imm_bits, w_word;
  logic        w_range_ok, w_accept, w_start;
  logic        w_use_rd, w_use_f3, w_use_rs1, w_use_rs2;
  logic [1:0]  w_unused_base;

  assign w_unused_base = base_addr[1:0];

  imm_pack u_imm_pack (
    .i_class    (req_class),
    .i_imm      (imm),
    .o_imm_bits (w_imm_bits),
    .o_range_ok (w_range_ok)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    w_accept  = (r_state == StRun) && req_valid;
    w_start   = start && (r_state != StRun);
    req_ready = (r_state == StRun);
    done      = (r_state == StDone);
    unique case (r_state)
      StIdle, StDone: if (start) w_state_d = StRun;
      StRun:          if (w_accept && (req_last || !w_range_ok)) w_state_d = StDone;
      default:        w_state_d = StIdle;
    endcase
  end

  // Which register/funct fields the class carries; the rest stay zero or hold imm bits.
  always_comb begin
    w_use_rd  = 1'b0;
    w_use_f3  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (req_class)
      ClsLoad, ClsIAlu:   begin w_use_rd = 1'b1; w_use_f3 = 1'b1; w_use_rs1 = 1'b1; end
      ClsStore, ClsBranch: begin w_use_f3 = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; end
      ClsR: begin
        w_use_rd = 1'b1; w_use_f3 = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
      end
      ClsJal, ClsAuipc, ClsLui: w_use_rd = 1'b1;
      ClsJalr:            begin w_use_rd = 1'b1; w_use_rs1 = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    w_word = w_imm_bits | {25'b0, class_opcode(req_class)};
    if (w_use_rd)  w_word[11:7]  = w_word[11:7] | rd;
    if (w_use_f3)  w_word[14:12] = funct3;
    if (w_use_rs1) w_word[19:15] = rs1;
    if (w_use_rs2) w_word[24:20] = rs2;
    if (req_class == ClsR) w_word[31:25] = {1'b0, funct7b5, 5'b00000};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_next_addr <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_count     <= '0;
      r_we        <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_next_addr <= {base_addr[31:2], 2'b00};
        r_count     <= '0;
        r_error     <= 1'b0;
      end else if (w_accept) begin
        if (w_range_ok) begin
          r_we        <= 1'b1;
          r_addr      <= r_next_addr;
          r_wdata     <= w_word;
          r_next_addr <= r_next_addr + 32'd4;
          r_count     <= r_count + 16'd1;
        end else begin
          // Rejected request: nothing written, address and count hold.
          r_error <= 1'b1;
        end
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign error      = r_error;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_class = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7b5 = 1'b0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        req_last = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic [15:0] count;
  logic        done, error;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] lit_q[$];

  instr_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_class  (req_class),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .req_last   (req_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .count      (count),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] fld(logic [31:0] v, int lo, logic [31:0] mask);
    return (v >> lo) & mask;
  endfunction

  function automatic logic [31:0] m_enc(logic [31:0] cls, logic [31:0] f3, logic [31:0] f7,
                                        logic [31:0] xd, logic [31:0] x1, logic [31:0] x2,
                                        logic [31:0] i);
    case (cls)
      0: return (fld(i, 0, 'hFFF) << 20) | (x1 << 15) | (f3 << 12) | (xd << 7) | 32'h03;
      1: return (fld(i, 5, 'h7F) << 25) | (x2 << 20) | (x1 << 15) | (f3 << 12)
              | (fld(i, 0, 'h1F) << 7) | 32'h23;
      2: return (f7 << 30) | (x2 << 20) | (x1 << 15) | (f3 << 12) | (xd << 7) | 32'h33;
      3: return (fld(i, 12, 1) << 31) | (fld(i, 5, 'h3F) << 25) | (x2 << 20) | (x1 << 15)
              | (f3 << 12) | (fld(i, 1, 'hF) << 8) | (fld(i, 11, 1) << 7) | 32'h63;
      4: return (fld(i, 0, 'hFFF) << 20) | (x1 << 15) | (f3 << 12) | (xd << 7) | 32'h13;
      5: return (fld(i, 20, 1) << 31) | (fld(i, 1, 'h3FF) << 21) | (fld(i, 11, 1) << 20)
              | (fld(i, 12, 'hFF) << 12) | (xd << 7) | 32'h6F;
      6: return (i & 32'hFFFFF000) | (xd << 7) | 32'h17;
      7: return (i & 32'hFFFFF000) | (xd << 7) | 32'h37;
      8: return (fld(i, 0, 'hFFF) << 20) | (x1 << 15) | (xd << 7) | 32'h67;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_legal(logic [31:0] cls, logic [31:0] i);
    int s;
    s = i;
    case (cls)
      0, 1, 4, 8: return (s >= -2048) && (s <= 2047);
      2:          return 1'b1;
      3:          return (s >= -4096) && (s <= 4095) && !i[0];
      5:          return (s >= -(1 << 20)) && (s < (1 << 20)) && !i[0];
      6, 7:       return (i & 32'hFFF) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  bit          m_running, m_done, m_err, m_we;
  logic [15:0] m_count;
  logic [31:0] m_na, m_addr, m_wdata;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_running <= 0; m_done <= 0; m_err <= 0; m_we <= 0;
      m_count <= '0; m_na <= '0; m_addr <= '0; m_wdata <= '0;
    end else begin
      m_we <= 0;
      if (!m_running && start) begin
        m_running <= 1; m_done <= 0; m_err <= 0; m_count <= '0;
        m_na <= base_addr & 32'hFFFFFFFC;
      end else if (m_running && req_valid) begin
        if (m_legal({28'b0, req_class}, imm)) begin
          m_we    <= 1;
          m_addr  <= m_na;
          m_wdata <= m_enc({28'b0, req_class}, {29'b0, funct3}, {31'b0, funct7b5},
                           {27'b0, rd}, {27'b0, rs1}, {27'b0, rs2}, imm);
          m_na    <= m_na + 32'd4;
          m_count <= m_count + 16'd1;
          if (req_last) begin m_running <= 0; m_done <= 1; end
        end else begin
          m_err <= 1; m_running <= 0; m_done <= 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    logic [63:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("imem_we", 32'(imem_we), 32'(m_we));
      chk("req_ready", 32'(req_ready), 32'(m_running));
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_err));
      chk("count", 32'(count), 32'(m_count));
      if (m_we) begin
        chk("imem_addr", imem_addr, m_addr);
        chk("imem_wdata", imem_wdata, m_wdata);
      end
      if (reset) begin
        chk("reset_addr", imem_addr, 32'h0);
        chk("reset_wdata", imem_wdata, 32'h0);
      end
      if (imem_we) begin
        if (lit_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, expected no write",
                   imem_addr, imem_wdata);
        end else begin
          e = lit_q.pop_front();
          chk("lit_addr", imem_addr, e[63:32]);
          chk("lit_wdata", imem_wdata, e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(logic [31:0] b);
    start = 1'b1; base_addr = b; req_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  task automatic issue(logic [3:0] cls, logic [2:0] f3, logic f7, logic [4:0] xd,
                       logic [4:0] x1, logic [4:0] x2, logic [31:0] i, logic last,
                       logic push, logic [31:0] ea, logic [31:0] ew);
    req_class = cls; funct3 = f3; funct7b5 = f7; rd = xd; rs1 = x1; rs2 = x2;
    imm = i; req_last = last; req_valid = 1'b1;
    if (push) lit_q.push_back({ea, ew});
    tick();
    req_valid = 1'b0; req_last = 1'b0;
  endtask

  task automatic lit_at_negedge(string name, logic [31:0] act, logic [31:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    repeat (2) tick();
    @(negedge clk);
    lit_at_negedge("reset_ready", 32'(req_ready), 32'h0);
    lit_at_negedge("reset_count", 32'(count), 32'h0);
    #4 reset = 1'b0;
    tick();
    // req_valid in IDLE is ignored
    req_valid = 1'b1; tick(); req_valid = 1'b0;

    // addi x1, x0, 5
    do_start(32'h100);
    issue(4'd4, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 1, 32'h100, 32'h00500093);
    tick();
    // req_valid in DONE is ignored
    req_valid = 1'b1; tick(); tick(); req_valid = 1'b0;

    // lw x2, 8(x1); sw x2, 4(x1) back-to-back (store rd input must not leak)
    do_start(32'h100);
    issue(4'd0, 3'd2, 0, 5'd2, 5'd1, 5'd0, 32'd8, 0, 1, 32'h100, 32'h0080A103);
    issue(4'd1, 3'd2, 0, 5'd7, 5'd1, 5'd2, 32'd4, 1, 1, 32'h104, 32'h0020A223);
    @(negedge clk);
    lit_at_negedge("p2_count", 32'(count), 32'd2);
    lit_at_negedge("p2_done", 32'(done), 32'd1);
    tick();

    // beq x0,x0,-4; jal x1,8 (stray fields); lui x5,0x12345000 (stray fields)
    do_start(32'h200);
    issue(4'd3, 3'd0, 0, 5'd3, 5'd0, 5'd0, 32'hFFFFFFFC, 0, 1, 32'h200, 32'hFE000EE3);
    issue(4'd5, 3'd5, 1, 5'd1, 5'd7, 5'd9, 32'd8, 0, 1, 32'h204, 32'h008000EF);
    issue(4'd7, 3'd3, 1, 5'd5, 5'd4, 5'd6, 32'h12345000, 1, 1, 32'h208, 32'h123452B7);
    @(negedge clk);
    lit_at_negedge("p3_done", 32'(done), 32'd1);
    lit_at_negedge("p3_count", 32'(count), 32'd3);
    tick();

    // odd branch offset is rejected
    do_start(32'h300);
    issue(4'd3, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd3, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    lit_at_negedge("p4_error", 32'(error), 32'd1);
    lit_at_negedge("p4_done", 32'(done), 32'd1);
    lit_at_negedge("p4_count", 32'(count), 32'd0);
    tick();

    // base with low bits set wraps through 0; start clears error
    do_start(32'hFFFFFFFF);
    @(negedge clk);
    lit_at_negedge("p5_error_clr", 32'(error), 32'd0);
    lit_at_negedge("p5_done_clr", 32'(done), 32'd0);
    #4;
    issue(4'd2, 3'd0, 1, 5'd3, 5'd1, 5'd2, 32'hDEAD0000, 0, 1, 32'hFFFFFFFC, 32'h402081B3);
    issue(4'd6, 3'd2, 1, 5'd4, 5'd3, 5'd0, 32'h00001000, 0, 1, 32'h00000000, 32'h00001217);
    issue(4'd8, 3'd7, 0, 5'd1, 5'd5, 5'd0, 32'd16, 1, 1, 32'h00000004, 32'h010280E7);
    @(negedge clk);
    lit_at_negedge("p5_count", 32'(count), 32'd3);
    tick();

    // I boundary values; start during RUN is ignored; 2048 is out of range
    do_start(32'h500);
    issue(4'd4, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 0, 1, 32'h500, 32'h80000093);
    start = 1'b1; base_addr = 32'h900;
    issue(4'd1, 3'd2, 0, 5'd0, 5'd0, 5'd0, 32'h000007FF, 0, 1, 32'h504, 32'h7E002FA3);
    start = 1'b0;
    issue(4'd4, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'h00000800, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    lit_at_negedge("p6_count", 32'(count), 32'd2);
    lit_at_negedge("p6_error", 32'(error), 32'd1);
    tick();

    // illegal class
    do_start(32'h600);
    issue(4'd9, 3'd0, 0, 5'd1, 5'd1, 5'd1, 32'd0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    lit_at_negedge("p7_error", 32'(error), 32'd1);
    tick();

    // J boundary: -2^20 legal, +2^20 rejected
    do_start(32'h700);
    issue(4'd5, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'hFFF00000, 0, 1, 32'h700, 32'h8000006F);
    issue(4'd5, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'h00100000, 0, 0, 32'h0, 32'h0);
    tick();

    // U with nonzero low bits rejected
    do_start(32'h800);
    issue(4'd7, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345001, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    lit_at_negedge("p9_error", 32'(error), 32'd1);
    lit_at_negedge("p9_count", 32'(count), 32'd0);
    tick();

    // reset in the cycle after an accept discards the pending write
    do_start(32'hA00);
    issue(4'd4, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 0, 32'h0, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    lit_at_negedge("rst_we", 32'(imem_we), 32'd0);
    lit_at_negedge("rst_addr", imem_addr, 32'd0);
    lit_at_negedge("rst_wdata", imem_wdata, 32'd0);
    lit_at_negedge("rst_count", 32'(count), 32'd0);
    lit_at_negedge("rst_ready", 32'(req_ready), 32'd0);
    #4;
    tick();
    reset = 1'b0;
    tick();

    // recovery after reset
    do_start(32'h40);
    issue(4'd4, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd5, 1, 1, 32'h40, 32'h00500093);
    repeat (3) tick();
    @(negedge clk);
    chk("lit_queue_empty", lit_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
